// File: rtl/div_iter_axis_pkg.sv
`default_nettype none
// ============================================================================
// Module   : div_iter_axis_pkg
// Brief    : Shared width and FSM state encodings for the iterative divider.
// Revision : 1.0 - initial release
// ============================================================================
package div_iter_axis_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

endpackage
`default_nettype wire

// File: rtl/div_restore_step.sv
`default_nettype none
// ============================================================================
// Module   : div_restore_step
// Brief    : One combinational radix-2 restoring division iteration.
// Revision : 1.0 - initial release
// ============================================================================
module div_restore_step
    import div_iter_axis_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic [WIDTH-1:0] i_q,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_rem,
    output logic [WIDTH-1:0] o_q
);

    // The stored remainder is always below the divisor, so only the shifted
    // value needs the extra bit; its MSB after subtraction is the borrow.
    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_trial;

    assign w_shift = {i_rem, i_q[WIDTH-1]};
    assign w_trial = w_shift - {1'b0, i_divisor};

    always_comb begin
        o_rem = w_shift[WIDTH-1:0];
        o_q   = {i_q[WIDTH-2:0], 1'b0};
        if (!w_trial[WIDTH]) begin
            o_rem = w_trial[WIDTH-1:0];
            o_q   = {i_q[WIDTH-2:0], 1'b1};
        end
    end

endmodule
`default_nettype wire

// File: rtl/div_iter_axis.sv
`default_nettype none
// ============================================================================
// Module   : div_iter_axis
// Brief    : Iterative restoring divider with AXI-stream style operand/result.
// Revision : 1.0 - initial release
// ============================================================================
module div_iter_axis
    import div_iter_axis_pkg::*;
#(
    parameter int WIDTH  = DIV_WIDTH,
    parameter bit SIGNED = 1'b1
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [WIDTH-1:0]   s_axis_dividend_tdata,
    input  logic               s_axis_dividend_tvalid,
    output logic               s_axis_dividend_tready,
    input  logic [WIDTH-1:0]   s_axis_divisor_tdata,
    input  logic               s_axis_divisor_tvalid,
    output logic               s_axis_divisor_tready,
    output logic [2*WIDTH-1:0] m_axis_dout_tdata,
    output logic               m_axis_dout_tvalid
);

    localparam int                 c_cnt_w = $clog2(WIDTH);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);

    div_state_e          r_state;
    div_state_e          w_state_next;
    logic [WIDTH-1:0]    r_rem;
    logic [WIDTH-1:0]    r_q;
    logic [WIDTH-1:0]    r_divisor;
    logic [c_cnt_w-1:0]  r_count;
    logic                r_sign_q;
    logic                r_sign_r;
    logic [2*WIDTH-1:0]  r_tdata;
    logic                r_tvalid;

    logic                w_fire;
    logic                w_last;
    logic [WIDTH-1:0]    w_abs_a;
    logic [WIDTH-1:0]    w_abs_b;
    logic [WIDTH-1:0]    w_rem_next;
    logic [WIDTH-1:0]    w_q_next;
    logic [WIDTH-1:0]    w_q_fix;
    logic [WIDTH-1:0]    w_r_fix;

    assign w_fire  = (r_state == DIV_IDLE) && s_axis_dividend_tvalid && s_axis_divisor_tvalid;
    assign w_last  = (r_state == DIV_BUSY) && (r_count == c_last);
    assign w_abs_a = (SIGNED && s_axis_dividend_tdata[WIDTH-1]) ? -s_axis_dividend_tdata
                                                                 : s_axis_dividend_tdata;
    assign w_abs_b = (SIGNED && s_axis_divisor_tdata[WIDTH-1])  ? -s_axis_divisor_tdata
                                                                 : s_axis_divisor_tdata;

    div_restore_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_rem     (r_rem),
        .i_q       (r_q),
        .i_divisor (r_divisor),
        .o_rem     (w_rem_next),
        .o_q       (w_q_next)
    );

    // Sign fix-up applied to the final iteration's result; 0x80000000/-1
    // wraps naturally through the negation.
    assign w_q_fix = r_sign_q ? -w_q_next   : w_q_next;
    assign w_r_fix = r_sign_r ? -w_rem_next : w_rem_next;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= DIV_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            DIV_IDLE: if (w_fire) w_state_next = DIV_BUSY;
            DIV_BUSY: if (r_count == c_last) w_state_next = DIV_DONE;
            DIV_DONE: w_state_next = DIV_IDLE;
            default:  w_state_next = DIV_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rem     <= '0;
            r_q       <= '0;
            r_divisor <= '0;
            r_count   <= '0;
            r_sign_q  <= 1'b0;
            r_sign_r  <= 1'b0;
            r_tdata   <= '0;
            r_tvalid  <= 1'b0;
        end else begin
            if (w_fire) begin
                r_sign_q  <= SIGNED & (s_axis_dividend_tdata[WIDTH-1] ^ s_axis_divisor_tdata[WIDTH-1]);
                r_sign_r  <= SIGNED & s_axis_dividend_tdata[WIDTH-1];
                r_rem     <= '0;
                r_q       <= w_abs_a;
                r_divisor <= w_abs_b;
                r_count   <= '0;
            end else if (r_state == DIV_BUSY) begin
                r_rem   <= w_rem_next;
                r_q     <= w_q_next;
                r_count <= r_count + c_cnt_w'(1);
            end

            r_tvalid <= w_last;
            if (w_last) begin
                r_tdata <= {w_q_fix, w_r_fix};
            end
        end
    end

    assign s_axis_dividend_tready = (r_state == DIV_IDLE);
    assign s_axis_divisor_tready  = (r_state == DIV_IDLE);
    assign m_axis_dout_tdata      = r_tdata;
    assign m_axis_dout_tvalid     = r_tvalid;

endmodule
`default_nettype wire

// File: tb/tb_div_iter_axis.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_iter_axis
// Brief    : Directed and randomized checks of signed and unsigned dividers.
// Revision : 1.0 - initial release
// ============================================================================
module tb_div_iter_axis;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        av = 1'b0;
    logic        bv = 1'b0;

    logic        a_rdy_s, b_rdy_s, a_rdy_u, b_rdy_u;
    logic [63:0] dout_s, dout_u;
    logic        vs, vu;

    logic [63:0] prev_s = '0;
    logic [63:0] prev_u = '0;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    div_iter_axis #(.WIDTH(32), .SIGNED(1'b1)) dut_s (
        .clk                    (clk),
        .resetn                 (resetn),
        .s_axis_dividend_tdata  (a),
        .s_axis_dividend_tvalid (av),
        .s_axis_dividend_tready (a_rdy_s),
        .s_axis_divisor_tdata   (b),
        .s_axis_divisor_tvalid  (bv),
        .s_axis_divisor_tready  (b_rdy_s),
        .m_axis_dout_tdata      (dout_s),
        .m_axis_dout_tvalid     (vs)
    );

    div_iter_axis #(.WIDTH(32), .SIGNED(1'b0)) dut_u (
        .clk                    (clk),
        .resetn                 (resetn),
        .s_axis_dividend_tdata  (a),
        .s_axis_dividend_tvalid (av),
        .s_axis_dividend_tready (a_rdy_u),
        .s_axis_divisor_tdata   (b),
        .s_axis_divisor_tvalid  (bv),
        .s_axis_divisor_tready  (b_rdy_u),
        .m_axis_dout_tdata      (dout_u),
        .m_axis_dout_tvalid     (vu)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y, input bit sgn);
        logic [31:0] q;
        logic [31:0] r;
        if (y == 32'd0) begin
            q = (sgn && x[31]) ? 32'h1 : 32'hFFFF_FFFF;
            r = x;
        end else if (sgn && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'h0;
        end else if (sgn) begin
            q = 32'($signed(x) / $signed(y));
            r = 32'($signed(x) % $signed(y));
        end else begin
            q = x / y;
            r = x % y;
        end
        return {q, r};
    endfunction

    // Called one step after the handshake edge; follows the result through
    // to the cycle after its strobe.
    task automatic wait_done(input string tag, input logic [63:0] es, input logic [63:0] eu);
        int cnt;
        bit seen;
        cnt  = 1;
        seen = 1'b0;
        while (cnt < 60 && !seen) begin
            if (cnt == 20) begin
                check({tag, " busy_tready"}, {60'd0, a_rdy_s, b_rdy_s, a_rdy_u, b_rdy_u}, 64'd0);
                check({tag, " hold_s"}, dout_s, prev_s);
                check({tag, " hold_u"}, dout_u, prev_u);
            end
            tick();
            cnt++;
            seen = vs;
        end
        check({tag, " latency"}, 64'(cnt), 64'd33);
        check({tag, " tvalid_u"}, {63'd0, vu}, 64'd1);
        check({tag, " data_s"}, dout_s, es);
        check({tag, " data_u"}, dout_u, eu);
        prev_s = es;
        prev_u = eu;
        tick();
        check({tag, " strobe_len"}, {62'd0, vs, vu}, 64'd0);
        check({tag, " tready_back"}, {60'd0, a_rdy_s, b_rdy_s, a_rdy_u, b_rdy_u}, 64'hF);
    endtask

    task automatic run_pair(input string tag, input logic [31:0] da, input logic [31:0] db,
                            input logic [63:0] es, input logic [63:0] eu);
        a  = da;
        b  = db;
        av = 1'b1;
        bv = 1'b1;
        tick();
        av = 1'b0;
        bv = 1'b0;
        a  = ~da;
        b  = ~db;
        wait_done(tag, es, eu);
    endtask

    initial begin
        int strobes;
        logic [31:0] ra;
        logic [31:0] rb;

        // Reset state
        #12;
        check("rst_tvalid", {62'd0, vs, vu}, 64'd0);
        check("rst_tdata_s", dout_s, 64'd0);
        check("rst_tdata_u", dout_u, 64'd0);
        check("rst_tready", {60'd0, a_rdy_s, b_rdy_s, a_rdy_u, b_rdy_u}, 64'hF);
        tick();
        resetn = 1'b1;
        tick();

        // Directed vectors, hand-computed
        run_pair("100/7",  32'd100,        32'd7,          {32'h0000_000E, 32'h0000_0002}, {32'h0000_000E, 32'h0000_0002});
        run_pair("-7/2",   32'hFFFF_FFF9,  32'd2,          {32'hFFFF_FFFD, 32'hFFFF_FFFF}, {32'h7FFF_FFFC, 32'h0000_0001});
        run_pair("7/-2",   32'd7,          32'hFFFF_FFFE,  {32'hFFFF_FFFD, 32'h0000_0001}, {32'h0000_0000, 32'h0000_0007});
        run_pair("ovf",    32'h8000_0000,  32'hFFFF_FFFF,  {32'h8000_0000, 32'h0000_0000}, {32'h0000_0000, 32'h8000_0000});
        run_pair("5/0",    32'd5,          32'd0,          {32'hFFFF_FFFF, 32'h0000_0005}, {32'hFFFF_FFFF, 32'h0000_0005});
        run_pair("-7/0",   32'hFFFF_FFF9,  32'd0,          {32'h0000_0001, 32'hFFFF_FFF9}, {32'hFFFF_FFFF, 32'hFFFF_FFF9});

        // Only one operand valid: never captured
        a  = 32'd9;
        b  = 32'd3;
        av = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("half_tready%0d", i), {60'd0, a_rdy_s, b_rdy_s, a_rdy_u, b_rdy_u}, 64'hF);
        end
        av = 1'b0;
        strobes = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            strobes += int'(vs) + int'(vu);
        end
        check("half_no_strobe", 64'(strobes), 64'd0);

        // Operands held during BUSY are ignored, then taken right after DONE
        a  = 32'd100;
        b  = 32'd7;
        av = 1'b1;
        bv = 1'b1;
        tick();
        a  = 32'd50;
        b  = 32'd5;
        wait_done("bp_first", {32'h0000_000E, 32'h0000_0002}, {32'h0000_000E, 32'h0000_0002});
        tick();
        av = 1'b0;
        bv = 1'b0;
        wait_done("bp_second", {32'h0000_000A, 32'h0000_0000}, {32'h0000_000A, 32'h0000_0000});

        // Reset in the middle of a division
        a  = 32'd100;
        b  = 32'd7;
        av = 1'b1;
        bv = 1'b1;
        tick();
        av = 1'b0;
        bv = 1'b0;
        repeat (10) tick();
        resetn = 1'b0;
        #1;
        check("midrst_tvalid", {62'd0, vs, vu}, 64'd0);
        check("midrst_tdata_s", dout_s, 64'd0);
        check("midrst_tdata_u", dout_u, 64'd0);
        check("midrst_tready", {60'd0, a_rdy_s, b_rdy_s, a_rdy_u, b_rdy_u}, 64'hF);
        prev_s = '0;
        prev_u = '0;
        tick();
        resetn = 1'b1;
        strobes = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            strobes += int'(vs) + int'(vu);
        end
        check("midrst_no_strobe", 64'(strobes), 64'd0);
        run_pair("1000/3", 32'd1000, 32'd3, {32'h0000_014D, 32'h0000_0001}, {32'h0000_014D, 32'h0000_0001});

        // Back-to-back random pairs against the reference model
        for (int i = 0; i < 200; i++) begin
            ra = (i % 7 == 0) ? $urandom_range(0, 15) : $urandom;
            if (i % 16 == 0)      rb = 32'd0;
            else if (i % 5 == 0)  rb = -($urandom_range(1, 9));
            else if (i % 3 == 0)  rb = $urandom_range(1, 9);
            else                  rb = $urandom;
            run_pair($sformatf("rnd%0d", i), ra, rb, model(ra, rb, 1'b1), model(ra, rb, 1'b0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
